// File: rtl/dm_axi_bridge.sv
// dm_axi_bridge: CPU data-memory port to single-beat AXI4 master.
// Define DM_POSTED_WRITE_EN to collect write responses in the background.
module dm_axi_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W = 4,
  parameter logic [ID_W-1:0] MASTER_ID = ID_W'(4'h1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [3:0]        cpu_bweb,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              bus_err,
  output logic [ID_W-1:0]   arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [ID_W-1:0]   rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic [ID_W-1:0]   awid,
  output logic [ADDR_W-1:0] awaddr,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic [ID_W-1:0]   bid,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_A, S_RD_D, S_WR, S_WR_B, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic              err_q, err_d;
  logic              can_go;
  logic              r_bad, b_bad;
`ifdef DM_POSTED_WRITE_EN
  logic              b_pend_q, b_pend_d;
`endif

  assign r_bad = (rresp != 2'b00) || (rid != MASTER_ID) || !rlast;
  assign b_bad = (bresp != 2'b00) || (bid != MASTER_ID);

  assign arid    = MASTER_ID;
  assign araddr  = addr_q;
  assign arlen   = 8'd0;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign awid    = MASTER_ID;
  assign awaddr  = addr_q;
  assign awlen   = 8'd0;
  assign awsize  = 3'b010;
  assign awburst = 2'b01;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;

  assign cpu_rdata = rdata_q;
  assign bus_err   = err_q;
  assign cpu_stall = (cpu_read | cpu_write) && (state_q != S_DONE);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    err_d     = err_q;
    arvalid   = 1'b0;
    rready    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
`ifdef DM_POSTED_WRITE_EN
    // Outstanding B blocks new requests but drains in any state
    b_pend_d  = b_pend_q;
    can_go    = !b_pend_q;
    bready    = b_pend_q;
    if (b_pend_q && bvalid) begin
      b_pend_d = 1'b0;
      if (b_bad) err_d = 1'b1;
    end
`else
    can_go    = 1'b1;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (cpu_write && can_go) begin
          addr_d    = cpu_addr;
          wdata_d   = cpu_wdata;
          wstrb_d   = ~cpu_bweb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = S_WR;
        end else if (cpu_read && can_go) begin
          addr_d  = cpu_addr;
          state_d = S_RD_A;
        end
      end
      S_RD_A: begin
        arvalid = 1'b1;
        if (arready) state_d = S_RD_D;
      end
      S_RD_D: begin
        rready = 1'b1;
        if (rvalid) begin
          rdata_d = rdata;
          if (r_bad) err_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_WR: begin
        awvalid   = !aw_done_q;
        wvalid    = !w_done_q;
        aw_done_d = aw_done_q | awready;
        w_done_d  = w_done_q | wready;
        if (aw_done_d && w_done_d) begin
`ifdef DM_POSTED_WRITE_EN
          b_pend_d = 1'b1;
          state_d  = S_DONE;
`else
          state_d  = S_WR_B;
`endif
        end
      end
      S_WR_B: begin
        bready = 1'b1;
        if (bvalid) begin
          if (b_bad) err_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
`ifdef DM_POSTED_WRITE_EN
      b_pend_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      err_q     <= err_d;
`ifdef DM_POSTED_WRITE_EN
      b_pend_q  <= b_pend_d;
`endif
    end
  end

endmodule

// File: tb/tb_dm_axi_bridge.sv
// tb_dm_axi_bridge: random CPU traffic against an AXI slave model,
// checked with a word-memory reference and transaction counters.
module tb_dm_axi_bridge;

  localparam logic [3:0] MID = 4'h1;

  logic        clk, rst;
  logic        cpu_read, cpu_write;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]  cpu_bweb;
  logic        cpu_stall, bus_err;
  logic [3:0]  arid, rid, awid, bid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, wlast;
  logic [3:0]  wstrb;
  logic        bvalid, bready;

  dm_axi_bridge dut (
    .clk(clk), .rst(rst),
    .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_addr(cpu_addr), .cpu_bweb(cpu_bweb),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall), .bus_err(bus_err),
    .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid),
    .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               tag, got, exp);
    end
  endtask

  // Shared test data for words never written
  function automatic logic [31:0] fill(input logic [29:0] wa);
    return {wa[13:0], 2'b01, wa[15:0]} ^ 32'h5A3C_96E1;
  endfunction

  logic [31:0] smem [logic [29:0]];
  logic [31:0] mmem [logic [29:0]];

  function automatic logic [31:0] s_rd(input logic [29:0] wa);
    if (smem.exists(wa)) return smem[wa];
    return fill(wa);
  endfunction

  function automatic logic [31:0] m_rd(input logic [29:0] wa);
    if (mmem.exists(wa)) return mmem[wa];
    return fill(wa);
  endfunction

  // Slave knobs and observations
  int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  int inj = 0;
  int ar_n = 0, aw_n = 0, w_n = 0;
  int prot_err = 0, ordr_viol = 0;
  logic [31:0] last_awaddr, last_wdata;
  logic [3:0]  last_wstrb;

  logic [31:0] rq_addr [$];
  int          rq_inj [$];
  logic [31:0] awq [$];
  logic [35:0] wq [$];
  int          bq_inj [$];

  initial begin : slave
    int ar_c, r_c, aw_c, w_c, b_c;
    bit h_ar, h_r, h_aw, h_w, h_b;
    logic [31:0] s_araddr, s_awaddr, s_wdata;
    logic [3:0]  s_wstrb;
    bit ar_ok, aw_ok, w_ok;
    ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
    arready = 0; rvalid = 0; awready = 0;
    wready = 0; bvalid = 0;
    rid = MID; rdata = 0; rresp = 0; rlast = 1;
    bid = MID; bresp = 0;
    forever begin
      @(negedge clk);
      h_ar = arvalid && arready;
      h_r  = rvalid && rready;
      h_aw = awvalid && awready;
      h_w  = wvalid && wready;
      h_b  = bvalid && bready;
      s_araddr = araddr;
      s_awaddr = awaddr;
      s_wdata  = wdata;
      s_wstrb  = wstrb;
      ar_ok = arlen == 0 && arsize == 3'b010 &&
              arburst == 2'b01 && arid == MID;
      aw_ok = awlen == 0 && awsize == 3'b010 &&
              awburst == 2'b01 && awid == MID;
      w_ok  = wlast;
      if ((arvalid || awvalid) && bq_inj.size() != 0)
        ordr_viol++;
      @(posedge clk);
      #1;
      if (!rst) begin
        rq_addr.delete(); rq_inj.delete();
        awq.delete(); wq.delete(); bq_inj.delete();
        ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
        arready = 0; rvalid = 0; awready = 0;
        wready = 0; bvalid = 0;
      end else begin
        if (h_ar) begin
          ar_n++;
          if (!ar_ok) prot_err++;
          rq_addr.push_back(s_araddr);
          rq_inj.push_back(inj);
          ar_c = 0;
        end
        if (h_r) begin
          void'(rq_addr.pop_front());
          void'(rq_inj.pop_front());
          r_c = 0;
        end
        if (h_aw) begin
          aw_n++;
          if (!aw_ok) prot_err++;
          awq.push_back(s_awaddr);
          aw_c = 0;
        end
        if (h_w) begin
          w_n++;
          if (!w_ok) prot_err++;
          wq.push_back({s_wstrb, s_wdata});
          w_c = 0;
        end
        while (awq.size() != 0 && wq.size() != 0) begin
          logic [31:0] a, wd;
          logic [35:0] e;
          a = awq.pop_front();
          e = wq.pop_front();
          wd = s_rd(a[31:2]);
          for (int b = 0; b < 4; b++)
            if (e[32+b]) wd[8*b +: 8] = e[8*b +: 8];
          smem[a[31:2]] = wd;
          last_awaddr = a;
          last_wdata  = e[31:0];
          last_wstrb  = e[35:32];
          bq_inj.push_back(inj);
        end
        if (h_b) begin
          void'(bq_inj.pop_front());
          b_c = 0;
        end
        if (arvalid) begin
          arready = ar_c >= ar_dly; ar_c++;
        end else arready = 0;
        if (awvalid) begin
          awready = aw_c >= aw_dly; aw_c++;
        end else awready = 0;
        if (wvalid) begin
          wready = w_c >= w_dly; w_c++;
        end else wready = 0;
        if (rq_addr.size() != 0) begin
          rvalid = r_c >= r_dly; r_c++;
          rdata  = s_rd(rq_addr[0][31:2]);
          rresp  = (rq_inj[0] == 1) ? 2'b10 : 2'b00;
          rid    = (rq_inj[0] == 2) ? 4'h7 : MID;
          rlast  = rq_inj[0] != 3;
        end else rvalid = 0;
        if (bq_inj.size() != 0) begin
          bvalid = b_c >= b_dly; b_c++;
          bresp  = (bq_inj[0] == 1) ? 2'b10 : 2'b00;
          bid    = (bq_inj[0] == 2) ? 4'h9 : MID;
        end else bvalid = 0;
      end
    end
  end

  // Reference view of the CPU
  logic [31:0] last_rd = 0;
  bit          exp_err = 0;
  int          stall_n;

  task automatic do_req(input bit rd, input bit wr,
                        input logic [31:0] a,
                        input logic [3:0] bweb,
                        input logic [31:0] d,
                        input int i);
    int ar0, aw0, w0;
    bit done, err_pre;
    logic [31:0] wv;
    ar0 = ar_n; aw0 = aw_n; w0 = w_n;
    inj = i;
    cpu_read = rd; cpu_write = wr;
    cpu_addr = a; cpu_bweb = bweb; cpu_wdata = d;
    stall_n = 0;
    done = 0;
    #1;
    if (cpu_stall) stall_n++;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!cpu_stall) begin
        done = 1;
        break;
      end
      stall_n++;
    end
    check("req_done", 32'(done), 1);
    if (wr) begin
      wv = m_rd(a[31:2]);
      for (int b = 0; b < 4; b++)
        if (!bweb[b]) wv[8*b +: 8] = d[8*b +: 8];
      mmem[a[31:2]] = wv;
      check("aw_beats", aw_n - aw0, 1);
      check("w_beats", w_n - w0, 1);
      check("ar_beats_wr", ar_n - ar0, 0);
    end else if (rd) begin
      last_rd = m_rd(a[31:2]);
      check("ar_beats", ar_n - ar0, 1);
      check("aw_beats_rd", aw_n - aw0, 0);
    end
    err_pre = exp_err;
    if (i != 0) exp_err = 1;
    check("cpu_rdata", cpu_rdata, last_rd);
`ifdef DM_POSTED_WRITE_EN
    check("bus_err", 32'(bus_err),
          32'(wr ? err_pre : exp_err));
`else
    check("bus_err", 32'(bus_err), 32'(exp_err));
`endif
    cpu_read = 0;
    cpu_write = 0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int ar0;
    bit ok;
    rst = 0;
    cpu_read = 0; cpu_write = 0;
    cpu_addr = 0; cpu_bweb = 4'hF; cpu_wdata = 0;
    repeat (3) @(negedge clk);
    check("rst_valids",
          {arvalid, rready, awvalid, wvalid, bready}, 0);
    check("rst_rdata", cpu_rdata, 0);
    check("rst_err", 32'(bus_err), 0);
    check("rst_stall", 32'(cpu_stall), 0);
    rst = 1;
    @(negedge clk);

    smem[30'h400] = 32'hCAFE_F00D;
    mmem[30'h400] = 32'hCAFE_F00D;
    do_req(1, 0, 32'h0000_1000, 4'hF, 0, 0);
    check("rd_stall", stall_n, 3);
    check("rd_data", cpu_rdata, 32'hCAFE_F00D);

    do_req(0, 1, 32'h0000_2004, 4'b1100, 32'h1234_5678, 0);
`ifdef DM_POSTED_WRITE_EN
    check("wr_stall", stall_n, 2);
`else
    check("wr_stall", stall_n, 3);
`endif
    check("awaddr", last_awaddr, 32'h2004);
    check("wstrb", last_wstrb, 4'b0011);
    check("wdata", last_wdata, 32'h1234_5678);

    aw_dly = 5; w_dly = 2;
    do_req(0, 1, 32'h0000_2008, 4'b0000, 32'hA1B2_C3D4, 0);
    aw_dly = 0; w_dly = 0;

    do_req(1, 1, 32'h0000_200C, 4'b0101, 32'h0F0F_F0F0, 0);
    check("both_stall", stall_n,
`ifdef DM_POSTED_WRITE_EN
          2
`else
          3
`endif
          );

    // Flush: request dropped while the read is in flight
    ar0 = ar_n;
    cpu_addr = 32'h0000_1040;
    cpu_read = 1;
    repeat (3) @(negedge clk);
    cpu_read = 0;
    #1;
    check("flush_stall", 32'(cpu_stall), 0);
    repeat (6) @(negedge clk);
    last_rd = m_rd(30'h410);
    check("flush_ar", ar_n - ar0, 1);
    check("flush_rdata", cpu_rdata, last_rd);

`ifdef DM_POSTED_WRITE_EN
    b_dly = 4;
    do_req(0, 1, 32'h0000_3000, 4'b0000, 32'h5555_AAAA, 0);
    do_req(1, 0, 32'h0000_3000, 4'hF, 0, 0);
    check("post_wait", 32'(stall_n > 3), 1);
    check("post_order", ordr_viol, 0);
    b_dly = 0;
`endif

    do_req(1, 0, 32'h0000_1004, 4'hF, 0, 1);
    do_req(1, 0, 32'h0000_1008, 4'hF, 0, 0);
    do_req(0, 1, 32'h0000_100C, 4'b1000, 32'h7777_8888, 0);
    do_req(1, 0, 32'h0000_100C, 4'hF, 0, 0);
    check("err_sticky", 32'(bus_err), 1);

    // Reset while waiting for read data
    r_dly = 20;
    cpu_addr = 32'h0000_3100;
    cpu_read = 1;
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rready) begin
        ok = 1;
        break;
      end
    end
    check("reach_rd_d", 32'(ok), 1);
    cpu_read = 0;
    rst = 0;
    @(negedge clk);
    check("mid_rst_valids",
          {arvalid, rready, awvalid, wvalid, bready}, 0);
    check("mid_rst_rdata", cpu_rdata, 0);
    check("mid_rst_err", 32'(bus_err), 0);
    rst = 1;
    r_dly = 0;
    last_rd = 0;
    exp_err = 0;
    @(negedge clk);
    do_req(1, 0, 32'h0000_3100, 4'hF, 0, 0);
    check("post_rst_stall", stall_n, 3);

    for (int n = 0; n < 150; n++) begin
      int op, i;
      bit rd, wr;
      logic [31:0] a;
      logic [3:0] bw;
      op = $urandom_range(0, 9);
      rd = (op < 5) || (op == 9);
      wr = op >= 5;
      a = 32'h0000_0100 + {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      bw = 4'($urandom);
      ar_dly = $urandom_range(0, 3);
      r_dly  = $urandom_range(0, 3);
      aw_dly = $urandom_range(0, 3);
      w_dly  = $urandom_range(0, 3);
      b_dly  = $urandom_range(0, 3);
      i = 0;
      if ($urandom_range(0, 9) == 0)
        i = wr ? $urandom_range(1, 2) : $urandom_range(1, 3);
      do_req(rd, wr, a, bw, $urandom, i);
    end

    check("fixed_fields", prot_err, 0);
    check("b_before_next", ordr_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
